topk_sorted_cam: RTL

Top-K heavy-hitter tracker that consumes the per-address minimum count estimate produced by the count-min sketch min-reduction stage. It keeps the NUM_ENTRY largest (addr, count) pairs in a table sorted by count, updated in place every cycle. It also provides a sequential dump port that lets host logic read the table out entry by entry.

---
 rtl/topk_sorted_cam.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/topk_sorted_cam.sv
// Top-K heavy-hitter table: keeps the NUM_ENTRY largest (addr, count) estimates sorted by count,
// updated in place each cycle, with a sequential dump port for host readout.
module topk_sorted_cam #(
    parameter int NUM_ENTRY = 8,
    parameter int ADDR_SIZE = 22,
    parameter int CNT_SIZE  = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           query_rst_n,
    input  logic                           in_valid,
    input  logic [ADDR_SIZE-1:0]           in_addr,
    input  logic [CNT_SIZE-1:0]            in_cnt,
    input  logic                           rd_start,
    output logic                           rd_valid,
    output logic                           rd_entry_vld,
    output logic [ADDR_SIZE-1:0]           rd_addr,
    output logic [CNT_SIZE-1:0]            rd_cnt,
    output logic                           rd_last,
    output logic                           busy,
    output logic [$clog2(NUM_ENTRY+1)-1:0] occupancy,
    output logic [CNT_SIZE-1:0]            thr_cnt,
    output logic [15:0]                    drop_cnt
);
    localparam int PW = $clog2(NUM_ENTRY + 1);
    localparam int IW = $clog2(NUM_ENTRY);

    typedef enum logic {IDLE, DUMP} state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t                state_q;
    logic [IW-1:0]         idx_q;
    logic [15:0]           drop_q;
    logic                  rd_valid_q, rd_entry_vld_q, rd_last_q;
    logic [ADDR_SIZE-1:0]  rd_addr_q;
    logic [CNT_SIZE-1:0]   rd_cnt_q;

    logic [NUM_ENTRY-1:0]  vld_q, vld_d;
    logic [ADDR_SIZE-1:0]  addr_q [NUM_ENTRY];
    logic [ADDR_SIZE-1:0]  addr_d [NUM_ENTRY];
    logic [CNT_SIZE-1:0]   cnt_q  [NUM_ENTRY];
    logic [CNT_SIZE-1:0]   cnt_d  [NUM_ENTRY];

    logic                  est, accept, upd, hit;
    logic [PW-1:0]         p, occ;
    logic [IW-1:0]         m, idx_nxt;

    // Table update: because the table stays sorted, the slots with cnt >= in_cnt form a prefix,
    // so their population count is the insertion point for both a hit-with-increase and a miss.
    always_comb begin
        est     = in_valid && (in_cnt != '0);
        accept  = est && (state_q == IDLE);
        idx_nxt = idx_q + 1'b1;
        p       = '0;
        occ     = '0;
        hit     = 1'b0;
        m       = '0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            occ = occ + PW'(vld_q[i]);
            if (vld_q[i] && (cnt_q[i] >= in_cnt)) p = p + 1'b1;
            if (vld_q[i] && (addr_q[i] == in_addr)) begin
                hit = 1'b1;
                m   = IW'(i);
            end
        end
        upd    = accept && (hit ? (in_cnt > cnt_q[m]) : (p < PW'(NUM_ENTRY)));
        vld_d  = vld_q;
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (upd) begin
            for (int i = 1; i < NUM_ENTRY; i++) begin
                if ((PW'(i) > p) && (!hit || (IW'(i) <= m))) begin
                    vld_d[i]  = vld_q[i-1];
                    addr_d[i] = addr_q[i-1];
                    cnt_d[i]  = cnt_q[i-1];
                end
            end
            for (int i = 0; i < NUM_ENTRY; i++) begin
                if (PW'(i) == p) begin
                    vld_d[i]  = 1'b1;
                    addr_d[i] = in_addr;
                    cnt_d[i]  = in_cnt;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            vld_q <= '0;
        else if (!query_rst_n) vld_q <= '0;
        else                   vld_q <= vld_d;
    end

    // Payload is qualified by vld_q everywhere it is observed, so it carries no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ENTRY; i++) begin
            addr_q[i] <= addr_d[i];
            cnt_q[i]  <= cnt_d[i];
        end
    end

    // Dump sequencer; the first beat reads the post-update table so a same-edge estimate is included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            drop_q         <= '0;
            rd_valid_q     <= 1'b0;
            rd_entry_vld_q <= 1'b0;
            rd_addr_q      <= '0;
            rd_cnt_q       <= '0;
            rd_last_q      <= 1'b0;
        end else if (!query_rst_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            drop_q         <= '0;
            rd_valid_q     <= 1'b0;
            rd_entry_vld_q <= 1'b0;
            rd_addr_q      <= '0;
            rd_cnt_q       <= '0;
            rd_last_q      <= 1'b0;
        end else begin
            if ((state_q == DUMP) && est) drop_q <= sat_inc16(drop_q);
            case (state_q)
                IDLE: begin
                    if (rd_start) begin
                        state_q        <= DUMP;
                        idx_q          <= '0;
                        rd_valid_q     <= 1'b1;
                        rd_entry_vld_q <= vld_d[0];
                        rd_addr_q      <= vld_d[0] ? addr_d[0] : '0;
                        rd_cnt_q       <= vld_d[0] ? cnt_d[0] : '0;
                        rd_last_q      <= 1'b0;
                    end
                end
                DUMP: begin
                    if (idx_q == IW'(NUM_ENTRY - 1)) begin
                        state_q        <= IDLE;
                        rd_valid_q     <= 1'b0;
                        rd_entry_vld_q <= 1'b0;
                        rd_addr_q      <= '0;
                        rd_cnt_q       <= '0;
                        rd_last_q      <= 1'b0;
                    end else begin
                        idx_q          <= idx_nxt;
                        rd_entry_vld_q <= vld_q[idx_nxt];
                        rd_addr_q      <= vld_q[idx_nxt] ? addr_q[idx_nxt] : '0;
                        rd_cnt_q       <= vld_q[idx_nxt] ? cnt_q[idx_nxt] : '0;
                        rd_last_q      <= (idx_nxt == IW'(NUM_ENTRY - 1));
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_valid     = rd_valid_q;
    assign rd_entry_vld = rd_entry_vld_q;
    assign rd_addr      = rd_addr_q;
    assign rd_cnt       = rd_cnt_q;
    assign rd_last      = rd_last_q;
    assign busy         = (state_q == DUMP);
    assign occupancy    = occ;
    assign thr_cnt      = vld_q[NUM_ENTRY-1] ? cnt_q[NUM_ENTRY-1] : '0;
    assign drop_cnt     = drop_q;
endmodule
